// File: rtl/fixed_pkg.sv
// Shared Q(FRAC) fixed-point types and helpers for the renderer and its pixel shaders.
package fixed_pkg;

  localparam int unsigned BITS = 32;
  localparam int unsigned FRAC = 16;

  typedef logic signed [BITS-1:0] fixed_t;

  function automatic fixed_t to_fixed(input int v);
    return fixed_t'(v) <<< FRAC;
  endfunction

endpackage

// File: rtl/fixed_mul.sv
// Signed Q(FRAC) multiply with a single registered output stage.
module fixed_mul
  import fixed_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  fixed_t a,
  input  fixed_t b,
  output fixed_t p
);

  localparam int unsigned PW = 2 * BITS;

  logic signed [PW-1:0] full_c;

  assign full_c = PW'(a) * PW'(b);

  // Rescale to Q(FRAC) by arithmetic shift, keep the low BITS bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= fixed_t'(full_c >>> FRAC);
  end

endmodule

// File: rtl/escape_time_shader.sv
// Per-pixel escape-time fractal shader on the renderer's pixel-dispatch handshake.
// Iterates z = z^2 + c in fixed point; two cycles per iteration (multiply, update).
module escape_time_shader
  import fixed_pkg::*;
#(
  parameter int unsigned WIDTH    = 1280,
  parameter int unsigned HEIGHT   = 720,
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned STEP     = 154
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [$clog2(WIDTH)-1:0]  curr_x,
  input  logic [$clog2(HEIGHT)-1:0] curr_y,
  input  logic [31:0]               timer,
  output logic                      pixel_done,
  output logic [7:0]                color_out,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
  output logic                      busy
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam int unsigned NW = $clog2(MAX_ITER + 1);
  localparam int unsigned MW = BITS + 1;

  typedef enum logic [2:0] {BOOT, IDLE, MUL, UPD, DONE} state_t;

  state_t            state, state_next;
  fixed_t            cr, ci, zr, zi;
  fixed_t            zr2, zi2, zrzi;
  fixed_t            cr_c, ci_c;
  logic [NW-1:0]     n;
  logic [7:0]        timer_lat;
  logic [XW-1:0]     job_x;
  logic [YW-1:0]     job_y;
  logic signed [MW-1:0] mag_c;
  logic              escaped_c, last_c;
  logic              accept_c, iterate_c, finish_c;
  logic [7:0]        color_c;
  logic              unused_timer_c;

  assign unused_timer_c = ^timer[31:8];

  assign cr_c      = (fixed_t'(curr_x) - fixed_t'(WIDTH / 2)) * fixed_t'(STEP);
  assign ci_c      = (fixed_t'(curr_y) - fixed_t'(HEIGHT / 2)) * fixed_t'(STEP);
  assign mag_c     = MW'(zr2) + MW'(zi2);
  assign escaped_c = mag_c > MW'(to_fixed(4));
  assign last_c    = (n == NW'(MAX_ITER - 1));

  fixed_mul u_mul_rr (.clk(clk_in), .rst_n(rst_in), .a(zr), .b(zr), .p(zr2));
  fixed_mul u_mul_ii (.clk(clk_in), .rst_n(rst_in), .a(zi), .b(zi), .p(zi2));
  fixed_mul u_mul_ri (.clk(clk_in), .rst_n(rst_in), .a(zr), .b(zi), .p(zrzi));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= BOOT;
    else         state <= state_next;
  end

  // BOOT emits a dummy completion so the dispatcher starts issuing work.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    iterate_c  = 1'b0;
    finish_c   = 1'b0;
    color_c    = 8'd0;
    case (state)
      BOOT: begin
        state_next = DONE;
        finish_c   = 1'b1;
      end
      IDLE: begin
        if (start_in) begin
          state_next = MUL;
          accept_c   = 1'b1;
        end
      end
      MUL: state_next = UPD;
      UPD: begin
        if (escaped_c) begin
          state_next = DONE;
          finish_c   = 1'b1;
          color_c    = 8'(n) + timer_lat;
        end else if (last_c) begin
          state_next = DONE;
          finish_c   = 1'b1;
        end else begin
          state_next = MUL;
          iterate_c  = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = BOOT;
    endcase
  end

  // Job registers and result outputs; z arithmetic wraps in BITS by design.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cr         <= '0;
      ci         <= '0;
      zr         <= '0;
      zi         <= '0;
      n          <= '0;
      timer_lat  <= '0;
      job_x      <= '0;
      job_y      <= '0;
      pixel_done <= 1'b0;
      color_out  <= '0;
      out_x      <= '0;
      out_y      <= '0;
      busy       <= 1'b0;
    end else begin
      if (accept_c) begin
        cr        <= cr_c;
        ci        <= ci_c;
        zr        <= '0;
        zi        <= '0;
        n         <= '0;
        timer_lat <= timer[7:0];
        job_x     <= curr_x;
        job_y     <= curr_y;
      end
      if (iterate_c) begin
        zr <= zr2 - zi2 + cr;
        zi <= (zrzi <<< 1) + ci;
        n  <= n + NW'(1);
      end
      pixel_done <= finish_c;
      if (finish_c) begin
        color_out <= color_c;
        out_x     <= job_x;
        out_y     <= job_y;
      end
      busy <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_escape_time_shader.sv
// Directed and randomized bench for escape_time_shader against an arithmetic reference model.
module tb_escape_time_shader;

  localparam int WIDTH    = 1280;
  localparam int HEIGHT   = 720;
  localparam int MAX_ITER = 64;
  localparam int STEP     = 154;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b0;
  logic        start_in = 1'b0;
  logic [10:0] curr_x   = '0;
  logic [9:0]  curr_y   = '0;
  logic [31:0] timer    = '0;
  logic        pixel_done;
  logic [7:0]  color_out;
  logic [10:0] out_x;
  logic [9:0]  out_y;
  logic        busy;

  int total = 0;
  int bad   = 0;

  escape_time_shader dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (start_in),
    .curr_x    (curr_x),
    .curr_y    (curr_y),
    .timer     (timer),
    .pixel_done(pixel_done),
    .color_out (color_out),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Escape-time reference: plain integer arithmetic, Q16 with truncating rescale.
  function automatic void ref_pixel(input int x, input int y, input int unsigned t,
                                    output int color, output int lat);
    int cr, ci, zr, zi, a, b, p;
    longint mag;
    cr = (x - WIDTH / 2) * STEP;
    ci = (y - HEIGHT / 2) * STEP;
    zr = 0;
    zi = 0;
    color = 0;
    lat = 2 * MAX_ITER + 1;
    for (int n = 0; n < MAX_ITER; n++) begin
      a   = int'((longint'(zr) * longint'(zr)) >>> 16);
      b   = int'((longint'(zi) * longint'(zi)) >>> 16);
      p   = int'((longint'(zr) * longint'(zi)) >>> 16);
      mag = longint'(a) + longint'(b);
      if (mag > 64'sd262144) begin
        color = (n + int'(t & 32'd255)) & 255;
        lat   = 2 * n + 3;
        return;
      end
      zr = a - b + cr;
      zi = 2 * p + ci;
    end
  endfunction

  // Issue one job from an IDLE cycle; ends in the IDLE cycle after the result.
  task automatic run_job(input int x, input int y, input int unsigned t,
                         input bit extra, input string tag);
    int exp_c, exp_l, k;
    bit seen;
    ref_pixel(x, y, t, exp_c, exp_l);
    curr_x   = 11'(x);
    curr_y   = 10'(y);
    timer    = t;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    k = 1;
    seen = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    while (k <= 2 * MAX_ITER + 8) begin
      if (pixel_done) begin
        seen = 1'b1;
        break;
      end
      if (extra && (k == 2 || k == 3 || k == 5)) begin
        curr_x   = 11'd7;
        curr_y   = 10'd9;
        timer    = 32'd99;
        start_in = 1'b1;
      end else begin
        start_in = 1'b0;
      end
      tick();
      k++;
    end
    start_in = 1'b0;
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_lat"}, 64'(k), 64'(exp_l));
      chk({tag, "_color"}, 64'(color_out), 64'(exp_c));
      chk({tag, "_x"}, 64'(out_x), 64'(x));
      chk({tag, "_y"}, 64'(out_y), 64'(y));
    end
    tick();
    chk({tag, "_pulse"}, 64'(pixel_done), 64'd0);
    chk({tag, "_hold"}, 64'(color_out), 64'(exp_c));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Release reset and expect exactly one bootstrap completion at (0,0) colour 0.
  task automatic boot_check(input string tag);
    int cnt, first;
    logic [7:0]  c;
    logic [10:0] bx;
    logic [9:0]  by;
    cnt = 0;
    first = -1;
    c  = '1;
    bx = '1;
    by = '1;
    rst_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (pixel_done) begin
        cnt++;
        if (first < 0) begin
          first = k;
          c  = color_out;
          bx = out_x;
          by = out_y;
        end
      end
    end
    chk({tag, "_count"}, 64'(cnt), 64'd1);
    chk({tag, "_cycle"}, 64'(first), 64'd1);
    chk({tag, "_color"}, 64'(c), 64'd0);
    chk({tag, "_x"}, 64'(bx), 64'd0);
    chk({tag, "_y"}, 64'(by), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int gi, gj;
    rst_in = 1'b0;
    tick();
    tick();
    chk("rst_done", 64'(pixel_done), 64'd0);
    chk("rst_color", 64'(color_out), 64'd0);
    chk("rst_x", 64'(out_x), 64'd0);
    chk("rst_y", 64'(out_y), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    boot_check("boot");

    run_job(WIDTH / 2, HEIGHT / 2, 32'd0, 1'b0, "center");
    run_job(WIDTH - 1, HEIGHT / 2, 32'd0, 1'b0, "edge");
    run_job(WIDTH - 1, HEIGHT / 2, 32'd255, 1'b0, "wrap");
    run_job(WIDTH - 1, HEIGHT / 2, 32'd0, 1'b1, "ignore");
    run_job(0, 0, 32'd17, 1'b0, "corner");

    // Reset in the middle of a long job.
    curr_x   = 11'(WIDTH / 2);
    curr_y   = 10'(HEIGHT / 2);
    timer    = 32'd0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    rst_in = 1'b0;
    #1;
    chk("midrst_done", 64'(pixel_done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_color", 64'(color_out), 64'd0);
    chk("midrst_x", 64'(out_x), 64'd0);
    tick();
    tick();
    boot_check("reboot");

    // Random sample of the 64x36 grid, back-to-back jobs with random timers.
    for (int r = 0; r < 180; r++) begin
      gi = int'($urandom_range(0, 63));
      gj = int'($urandom_range(0, 35));
      run_job(gi * 20, gj * 20, $urandom, 1'b0, "grid");
    end
    for (int r = 0; r < 20; r++) begin
      run_job(int'($urandom_range(0, WIDTH - 1)), int'($urandom_range(0, HEIGHT - 1)),
              $urandom, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
